// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: state encoding and default widths.
package counter_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_PRESC_WIDTH = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// Enabled tick divider: one tick every div+1 enabled cycles, count wraps on the tick.
module counter_prescaler #(
    parameter int PRESC_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic [PRESC_WIDTH-1:0] div,
    output logic                   tick
);

    logic [PRESC_WIDTH-1:0] cnt;

    assign tick = en && (cnt == div);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == div) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_down_timer.sv
// Loadable down-counting timer with prescaled tick, pause, abort and auto-reload.
//   state   | meaning
//   IDLE    | waiting for a load; load_ready high unless abort
//   RUN     | counting down on prescaled ticks; busy high
module counter_down_timer
    import counter_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int PRESC_WIDTH = DEF_PRESC_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [WIDTH-1:0]       load_value,
    input  logic                   load_reload,
    input  logic [PRESC_WIDTH-1:0] load_prescale,
    input  logic                   enable,
    input  logic                   abort,
    output logic [WIDTH-1:0]       count,
    output logic                   busy,
    output logic                   expired
);

    logic [0:0]             state;
    logic [PRESC_WIDTH-1:0] presc_q;
    logic                   reload_q;
    logic [WIDTH-1:0]       reload_val_q;
    logic                   accept;
    logic                   tick;

    assign load_ready = (state == ST_IDLE) && !abort;
    assign accept     = load_valid && load_ready;
    assign busy       = (state == ST_RUN);

    counter_prescaler #(
        .PRESC_WIDTH(PRESC_WIDTH)
    ) u_presc (
        .clk (clk),
        .rst (rst),
        .clr (abort || accept),
        .en  ((state == ST_RUN) && enable),
        .div (presc_q),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            count        <= '0;
            expired      <= 1'b0;
            presc_q      <= '0;
            reload_q     <= 1'b0;
            reload_val_q <= '0;
        end else begin
            expired <= 1'b0;
            if (abort) begin
                state    <= ST_IDLE;
                count    <= '0;
                reload_q <= 1'b0;
            end else if (accept) begin
                count        <= load_value;
                presc_q      <= load_prescale;
                reload_q     <= load_reload;
                reload_val_q <= load_value;
                // A zero load expires immediately and never enters RUN, so reload cannot loop.
                if (load_value == '0) begin
                    expired <= 1'b1;
                end else begin
                    state <= ST_RUN;
                end
            end else if (tick) begin
                if (count > WIDTH'(1)) begin
                    count <= count - 1'b1;
                end else if (count == WIDTH'(1)) begin
                    expired <= 1'b1;
                    if (reload_q) begin
                        count <= reload_val_q;
                    end else begin
                        count <= '0;
                        state <= ST_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_down_timer.sv
// Self-checking bench: directed scenarios with literal expectations plus random traffic
// compared every cycle against an elapsed-cycle arithmetic model of the timer.
module tb_counter_down_timer;

    logic       clk = 1'b0;
    logic       rst, load_valid, load_reload, enable, abort;
    logic [7:0] load_value;
    logic [3:0] load_prescale;
    logic       load_ready, busy, expired;
    logic [7:0] count;

    int tests = 0;
    int fails = 0;

    counter_down_timer #(.WIDTH(8), .PRESC_WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_value   (load_value),
        .load_reload  (load_reload),
        .load_prescale(load_prescale),
        .enable       (enable),
        .abort        (abort),
        .count        (count),
        .busy         (busy),
        .expired      (expired)
    );

    always #5 clk = ~clk;

    // Model: remaining count derived from enabled cycles elapsed since the load.
    bit m_run = 0;
    bit m_rl  = 0;
    bit m_exp = 0;
    int m_cnt = 0;
    int m_L = 0, m_P = 0, m_e = 0;

    always @(posedge clk) begin
        int per;
        m_exp = 0;
        if (rst) begin
            m_run = 0;
            m_cnt = 0;
        end else if (abort) begin
            m_run = 0;
            m_cnt = 0;
        end else if (!m_run && load_valid) begin
            if (load_value == 0) begin
                m_cnt = 0;
                m_exp = 1;
            end else begin
                m_run = 1;
                m_L   = load_value;
                m_P   = load_prescale;
                m_rl  = load_reload;
                m_e   = 0;
                m_cnt = m_L;
            end
        end else if (m_run && enable) begin
            m_e++;
            per = m_L * (m_P + 1);
            if (m_e % per == 0) begin
                m_exp = 1;
                if (m_rl) begin
                    m_cnt = m_L;
                end else begin
                    m_cnt = 0;
                    m_run = 0;
                end
            end else begin
                m_cnt = m_L - (m_e % per) / (m_P + 1);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    bit chk_on = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_count",      32'(count),      32'(m_cnt));
            check("model_busy",       32'(busy),       32'(m_run));
            check("model_expired",    32'(expired),    32'(m_exp));
            check("model_load_ready", 32'(load_ready), 32'(!m_run && !abort));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_load(input int v, input int p, input bit rl);
        load_valid    = 1'b1;
        load_value    = 8'(v);
        load_prescale = 4'(p);
        load_reload   = rl;
        cyc();
        load_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_value = '0; load_prescale = '0;
        load_reload = 1'b0; enable = 1'b0; abort = 1'b0;
        cyc();
        chk_on = 1;
        cyc();
        rst = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_expired", 32'(expired), 0);
        check("rst_ready", 32'(load_ready), 1);

        // One-shot L=5 P=0
        enable = 1'b1;
        do_load(5, 0, 0);
        check("os_load_count", 32'(count), 5);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            check("os_count", 32'(count), 32'(5 - k));
            check("os_expired", 32'(expired), (k == 5) ? 1 : 0);
        end
        cyc();
        check("os_exp_drop", 32'(expired), 0);
        check("os_busy_done", 32'(busy), 0);
        check("os_ready_done", 32'(load_ready), 1);

        // Prescale P=2 with a 4-cycle pause after the first tick
        do_load(3, 2, 0);
        repeat (3) cyc();
        check("ps_first_tick", 32'(count), 2);
        enable = 1'b0;
        repeat (4) cyc();
        check("ps_pause_hold", 32'(count), 2);
        check("ps_pause_busy", 32'(busy), 1);
        enable = 1'b1;
        repeat (5) cyc();
        check("ps_no_early_exp", 32'(expired), 0);
        cyc();
        check("ps_expired_13", 32'(expired), 1);
        check("ps_count_zero", 32'(count), 0);

        // Auto-reload L=4 P=0, load_valid held during RUN must not be taken
        do_load(4, 0, 1);
        load_valid = 1'b1; load_value = 8'd9;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            check("rl_expired", 32'(expired), (i % 4 == 0) ? 1 : 0);
            check("rl_count", 32'(count), 32'(4 - (i % 4)));
            check("rl_busy", 32'(busy), 1);
        end
        load_valid = 1'b0;
        repeat (2) cyc();
        check("ab_pre_count", 32'(count), 2);

        // Abort on an edge that is also a tick
        abort = 1'b1;
        #1 check("ab_ready_low", 32'(load_ready), 0);
        cyc();
        abort = 1'b0;
        check("ab_count", 32'(count), 0);
        check("ab_busy", 32'(busy), 0);
        check("ab_no_exp", 32'(expired), 0);
        do_load(7, 0, 0);
        check("ab_reload7_busy", 32'(busy), 1);
        check("ab_reload7_count", 32'(count), 7);
        abort = 1'b1; cyc(); abort = 1'b0;

        // Zero load with reload requested
        do_load(0, 0, 1);
        check("z_expired", 32'(expired), 1);
        check("z_busy", 32'(busy), 0);
        check("z_count", 32'(count), 0);
        cyc();
        check("z_exp_once", 32'(expired), 0);

        // Continuous expiry for L=1 P=0 reload
        do_load(1, 0, 1);
        repeat (3) cyc();
        check("l1_expired", 32'(expired), 1);
        check("l1_count", 32'(count), 1);

        // Reset mid-run
        do_load(9, 0, 0);
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        check("mr_count", 32'(count), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_expired", 32'(expired), 0);
        check("mr_ready", 32'(load_ready), 1);
        rst = 1'b0;

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            load_valid    = ($urandom_range(0, 3) == 0);
            load_value    = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            load_prescale = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            load_reload   = $urandom_range(0, 1);
            enable        = ($urandom_range(0, 6) != 0);
            abort         = ($urandom_range(0, 60) == 0);
            rst           = ($urandom_range(0, 200) == 0);
            cyc();
        end
        rst = 1'b0; abort = 1'b0; load_valid = 1'b0;
        cyc();
        chk_on = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/counter_down_timer.md
Name: counter_down_timer

Overview:
- Loadable down-counting timer. It is the consuming end of the counter family: it accepts a count value over a valid/ready load interface, counts it down to zero and signals expiry.
- Provides a prescaled tick, pause via enable, abort, and an optional auto-reload mode.
- Sits beside counter_basic in the Counter area, for timeouts and periodic event generation.

Parameters:
- WIDTH, 8, width of the count and load value.
- PRESC_WIDTH, 4, width of the prescale divider field.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- load_valid  input  1  load request; qualified by load_ready.
- load_ready  output  1  high when a load can be accepted.
- load_value  input  WIDTH  initial count; sampled on handshake.
- load_reload  input  1  auto-reload enable; sampled on handshake.
- load_prescale  input  PRESC_WIDTH  tick divider P, giving one decrement per P+1 enabled cycles; sampled on handshake.
- enable  input  1  high = run; low = pause.
- abort  input  1  cancel the current operation.
- count  output  WIDTH  current remaining count.
- busy  output  1  high while in RUN.
- expired  output  1  one-cycle pulse when the count reaches zero.

Behaviour:
- States: IDLE, RUN. Encoding comes from the shared package.
- Reset (rst=1 at a clock edge):
  - state=IDLE; count=0; expired=0; busy=0.
  - Prescaler count, latched prescale, latched reload flag and latched reload value all cleared.
  - load_ready=1 from the first cycle after reset.
- load_ready = (state==IDLE) && !abort. It is combinational from state and abort.
- Handshake: a load is accepted at the edge where load_valid && load_ready.
  - count <= load_value.
  - Latch P, the reload flag and the reload value.
  - Prescaler count <= 0.
  - Next state = RUN.
- Load value 0:
  - count <= 0, expired <= 1 at the acceptance edge, state stays IDLE.
  - The reload flag is ignored, so there is no perpetual expiry.
- In RUN:
  - With enable=1 the prescaler increments each cycle. When it equals P, a tick occurs and the prescaler wraps to 0.
  - With enable=0 the prescaler and count hold. busy stays 1.
- On a tick with count>1: count <= count-1.
- On a tick with count==1: expired <= 1 for exactly one cycle, then:
  - reload=1: count <= latched reload value, stay RUN. count never shows 0.
  - reload=0: count <= 0, state <= IDLE.
- Latency: with load L≥1, prescale P and enable held high, expired is high in the cycle after edge L*(P+1), counted from the acceptance edge as edge 0.
  - In reload mode, expired then repeats every L*(P+1) cycles.
- abort=1 in any state:
  - At the next edge: state=IDLE, count=0, prescaler=0, reload flag cleared.
  - No expired pulse, even if a tick coincides.
  - Priority: rst > abort > load handshake > tick. With abort=1, load_ready=0, so no load is accepted.
- load_valid while RUN: not accepted. The source must hold it; it is accepted after return to IDLE.
- expired is registered, deasserts the following cycle, and is never high for two consecutive cycles unless P=0 and L=1 in reload mode.
  - In that case expired stays high continuously. This is legal and required.
- count is plain unsigned. There is no underflow: decrement occurs only when count≥1.

Decomposition:
- Package counter_pkg:
  - State typedef/localparams: ST_IDLE=1'b0, ST_RUN=1'b1.
  - Default WIDTH/PRESC_WIDTH constants, shared with counter_basic.
- Sub-module counter_prescaler (PRESC_WIDTH):
  - Inputs: clk, rst, clr, en, div.
  - Output: tick. It is high in the cycle the internal count equals div while en=1, and the count wraps to 0 in that cycle.
  - The top instantiates one.

Test Plan:
- Reset with rst=1 for 2 cycles, then release → count=0, busy=0, expired=0, load_ready=1.
- One-shot with L=5, P=0, enable=1 → count 5,4,3,2,1,0 on successive edges. expired is a single pulse the cycle after edge 5. Then busy=0 and load_ready=1.
- Prescale and pause with L=3, P=2, and enable dropped for 4 cycles after the first tick → decrements every 3 enabled cycles. count holds during the pause. expired appears at 9+4 cycles after acceptance.
- Auto-reload with L=4, P=0, reload=1, run 20 cycles → expired at cycles 4, 8, 12, 16, 20. count cycles 4,3,2,1,4. busy stays 1. load_valid held during RUN is not accepted.
- Abort while count=2 coincides with a tick edge → count=0, IDLE, no expired pulse. A subsequent load of 7 is accepted the next cycle.
- Load 0 with reload=1 → expired pulses once, state stays IDLE, count=0. Then rst asserted mid-RUN after a load of 9 → all outputs return to reset values at the next edge.
